// File: rtl/filter_ctrl_pkg.sv
// Shared types and defaults for the IIR filter sequencer (filter_ctrl) and its rate divider.
package filter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int COEF_W_DEF = 4;
  localparam int DIV_W_DEF  = 16;

  localparam logic [7:0] OVR_MAX = 8'hFF;

  // Saturating increment for the dropped-tick counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == OVR_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/filter_ctrl_rate_tick.sv
// Sample-rate divider: one tick every rate_div+1 enabled cycles; disabled holds the count at 0.
module rate_tick
  import filter_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] rate_div,
  output logic             tick
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  // A shrunken rate_div leaves count above the limit; wrap silently without a tick.
  always_comb begin
    count_d = count_q;
    tick    = 1'b0;
    if (!enable) begin
      count_d = '0;
    end else if (count_q == rate_div) begin
      tick    = 1'b1;
      count_d = '0;
    end else if (count_q > rate_div) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/filter_ctrl.sv
// Sequencer for the cascaded IIR filter: launch, frozen sample/coefs, result capture, overrun count.
// Optional WAIT abort counter enabled by defining FILTER_CTRL_TIMEOUT_EN.
module filter_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int COEF_W      = COEF_W_DEF,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [COEF_W-1:0] a1_wr,
  input  logic [COEF_W-1:0] a2_wr,
  input  logic              coef_load,
  output logic              flt_once,
  output logic [DATA_W-1:0] flt_in,
  output logic [COEF_W-1:0] flt_a1,
  output logic [COEF_W-1:0] flt_a2,
  input  logic              flt_done,
  input  logic [DATA_W-1:0] flt_out,
  output logic [DATA_W-1:0] y,
  output logic              y_valid,
  output logic              busy,
  output logic              overrun,
  output logic [7:0]        ovr_count,
  output logic              timeout,
  output logic [1:0]        dbg_state
);

  // Filter handshake: flt_once is a single-cycle launch; flt_in/flt_a1/flt_a2 hold steady from
  // launch until the filter answers with a single-cycle flt_done (flt_out valid in that cycle).
  // flt_done is only accepted in WAIT; anywhere else it is dropped.

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   flt_in_q, flt_in_d;
  logic [COEF_W-1:0]   shadow_a1_q, shadow_a1_d;
  logic [COEF_W-1:0]   shadow_a2_q, shadow_a2_d;
  logic                pend_q, pend_d;
  logic [COEF_W-1:0]   act_a1_q, act_a1_d;
  logic [COEF_W-1:0]   act_a2_q, act_a2_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic                y_valid_q, y_valid_d;
  logic [7:0]          ovr_count_q, ovr_count_d;
  logic                tick;
  logic                to_hit;

  rate_tick #(
    .DIV_W(DIV_W)
  ) u_rate_tick (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .rate_div (rate_div),
    .tick     (tick)
  );

`ifdef FILTER_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            timeout_q, timeout_d;

  // Counts cycles spent in WAIT; a done in the final cycle still wins over the abort.
  always_comb begin
    wait_cnt_d = '0;
    to_hit     = 1'b0;
    if (state_q == WAIT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
      to_hit     = !flt_done && (wait_cnt_q == TO_W'(TIMEOUT_CYC - 1));
    end
    timeout_d = timeout_q | to_hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    hold_d      = adc_valid ? adc_data : hold_q;
    shadow_a1_d = coef_load ? a1_wr : shadow_a1_q;
    shadow_a2_d = coef_load ? a2_wr : shadow_a2_q;
    pend_d      = pend_q | coef_load;
    state_d     = state_q;
    flt_in_d    = flt_in_q;
    act_a1_d    = act_a1_q;
    act_a2_d    = act_a2_q;
    y_d         = y_q;
    y_valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick) begin
          // Launch: hold_d/shadow_*_d include same-cycle adc_valid and coef_load.
          state_d  = START;
          flt_in_d = hold_d;
          if (pend_d) begin
            act_a1_d = shadow_a1_d;
            act_a2_d = shadow_a2_d;
            pend_d   = 1'b0;
          end
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (flt_done) begin
          state_d   = IDLE;
          y_d       = flt_out;
          y_valid_d = 1'b1;
        end else if (to_hit) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ovr_count_d = overrun ? sat_inc(ovr_count_q) : ovr_count_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      flt_in_q    <= '0;
      shadow_a1_q <= '0;
      shadow_a2_q <= '0;
      pend_q      <= 1'b0;
      act_a1_q    <= '0;
      act_a2_q    <= '0;
      y_q         <= '0;
      y_valid_q   <= 1'b0;
      ovr_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      flt_in_q    <= flt_in_d;
      shadow_a1_q <= shadow_a1_d;
      shadow_a2_q <= shadow_a2_d;
      pend_q      <= pend_d;
      act_a1_q    <= act_a1_d;
      act_a2_q    <= act_a2_d;
      y_q         <= y_d;
      y_valid_q   <= y_valid_d;
      ovr_count_q <= ovr_count_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign overrun   = tick & busy;
  assign flt_once  = (state_q == START);
  assign flt_in    = flt_in_q;
  assign flt_a1    = act_a1_q;
  assign flt_a2    = act_a2_q;
  assign y         = y_q;
  assign y_valid   = y_valid_q;
  assign ovr_count = ovr_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_filter_ctrl.sv
// Directed bench for filter_ctrl: per-cycle vector table plus hand-built timing, saturation and reset runs.
module tb_filter_ctrl;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] rate_div;
  logic [15:0] adc_data;
  logic        adc_valid;
  logic [3:0]  a1_wr;
  logic [3:0]  a2_wr;
  logic        coef_load;
  logic        flt_once;
  logic [15:0] flt_in;
  logic [3:0]  flt_a1;
  logic [3:0]  flt_a2;
  logic        flt_done;
  logic [15:0] flt_out;
  logic [15:0] y;
  logic        y_valid;
  logic        busy;
  logic        overrun;
  logic [7:0]  ovr_count;
  logic        timeout;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic en; logic [15:0] rd; logic [15:0] ad; logic av;
    logic [3:0] a1; logic [3:0] a2; logic cl; logic fd; logic [15:0] fo;
    logic once; logic [15:0] fin; logic [3:0] a1o; logic [3:0] a2o;
    logic [15:0] yo; logic yv; logic bsy; logic ovr; logic [7:0] oc;
  } vec_t;

  vec_t tbl[17];

  filter_ctrl #(
    .TIMEOUT_CYC(15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .rate_div  (rate_div),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .a1_wr     (a1_wr),
    .a2_wr     (a2_wr),
    .coef_load (coef_load),
    .flt_once  (flt_once),
    .flt_in    (flt_in),
    .flt_a1    (flt_a1),
    .flt_a2    (flt_a2),
    .flt_done  (flt_done),
    .flt_out   (flt_out),
    .y         (y),
    .y_valid   (y_valid),
    .busy      (busy),
    .overrun   (overrun),
    .ovr_count (ovr_count),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int en, input int rd, input int ad, input int av,
                              input int a1, input int a2, input int cl, input int fd,
                              input int fo, input int once, input int fin, input int a1o,
                              input int a2o, input int yo, input int yv, input int bsy,
                              input int ovr, input int oc);
    vec_t v;
    v.en = 1'(en);    v.rd = 16'(rd);   v.ad = 16'(ad);   v.av = 1'(av);
    v.a1 = 4'(a1);    v.a2 = 4'(a2);    v.cl = 1'(cl);    v.fd = 1'(fd);
    v.fo = 16'(fo);   v.once = 1'(once); v.fin = 16'(fin); v.a1o = 4'(a1o);
    v.a2o = 4'(a2o);  v.yo = 16'(yo);   v.yv = 1'(yv);    v.bsy = 1'(bsy);
    v.ovr = 1'(ovr);  v.oc = 8'(oc);
    return v;
  endfunction

  // Driver tasks
  task automatic idle_inputs();
    enable = 1'b0; rate_div = '0; adc_data = '0; adc_valid = 1'b0;
    a1_wr = '0; a2_wr = '0; coef_load = 1'b0; flt_done = 1'b0; flt_out = '0;
  endtask

  // Leaves the bench 1 time unit after a posedge with rst released: the start of cycle 0.
  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " flt_once"}, 32'(flt_once), 0);
    chk({tag, " flt_in"}, 32'(flt_in), 0);
    chk({tag, " flt_a1"}, 32'(flt_a1), 0);
    chk({tag, " flt_a2"}, 32'(flt_a2), 0);
    chk({tag, " y"}, 32'(y), 0);
    chk({tag, " y_valid"}, 32'(y_valid), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " overrun"}, 32'(overrun), 0);
    chk({tag, " ovr_count"}, 32'(ovr_count), 0);
    chk({tag, " timeout"}, 32'(timeout), 0);
  endtask

  // rate_div=9, adc held at 1234, done 3 cycles after each once.
  task automatic run_rd9(input int ncyc, input string tag);
    logic [15:0] e;
    for (int c = 0; c < ncyc; c++) begin
      enable = 1'b1; rate_div = 16'd9; adc_data = 16'h1234; adc_valid = 1'b1;
      flt_done = (c >= 13) && (c % 10 == 3);
      flt_out  = 16'h1000 + 16'(c);
      if (flt_done) exp_q.push_back(flt_out);
      #3;
      chk($sformatf("%s c%0d flt_once", tag, c), 32'(flt_once), 32'((c >= 10) && (c % 10 == 0)));
      chk($sformatf("%s c%0d y_valid", tag, c), 32'(y_valid), 32'((c >= 14) && (c % 10 == 4)));
      chk($sformatf("%s c%0d timeout", tag, c), 32'(timeout), 0);
      if ((c >= 10) && (c % 10 == 0))
        chk($sformatf("%s c%0d flt_in", tag, c), 32'(flt_in), 32'h1234);
      if ((c >= 14) && (c % 10 == 4)) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        chk($sformatf("%s c%0d y", tag, c), 32'(y), 32'(e));
      end
      next_cycle();
    end
  endtask

  initial begin
    int model_oc;
    logic exp_ovr;

    tbl[0]  = mk(1, 2, 'h1111, 1, 3, 5, 1, 0, 0,       0, 0,      0, 0, 0,      0, 0, 0, 0);
    tbl[1]  = mk(1, 2, 0,      0, 0, 0, 0, 0, 0,       0, 0,      0, 0, 0,      0, 0, 0, 0);
    tbl[2]  = mk(1, 2, 'h2222, 1, 0, 0, 0, 0, 0,       0, 0,      0, 0, 0,      0, 0, 0, 0);
    tbl[3]  = mk(1, 2, 0,      0, 0, 0, 0, 1, 'hDEAD,  1, 'h2222, 3, 5, 0,      0, 1, 0, 0);
    tbl[4]  = mk(1, 2, 0,      0, 0, 0, 0, 1, 'h0ABC,  0, 'h2222, 3, 5, 0,      0, 1, 0, 0);
    tbl[5]  = mk(1, 2, 0,      0, 7, 1, 1, 0, 0,       0, 'h2222, 3, 5, 'h0ABC, 1, 0, 0, 0);
    tbl[6]  = mk(1, 2, 0,      0, 0, 0, 0, 0, 0,       1, 'h2222, 7, 1, 'h0ABC, 0, 1, 0, 0);
    tbl[7]  = mk(1, 2, 'h3333, 1, 2, 4, 1, 0, 0,       0, 'h2222, 7, 1, 'h0ABC, 0, 1, 0, 0);
    tbl[8]  = mk(1, 2, 0,      0, 0, 0, 0, 0, 0,       0, 'h2222, 7, 1, 'h0ABC, 0, 1, 1, 0);
    tbl[9]  = mk(1, 2, 0,      0, 0, 0, 0, 1, 'h5555,  0, 'h2222, 7, 1, 'h0ABC, 0, 1, 0, 1);
    tbl[10] = mk(1, 2, 0,      0, 0, 0, 0, 0, 0,       0, 'h2222, 7, 1, 'h5555, 1, 0, 0, 1);
    tbl[11] = mk(1, 2, 0,      0, 0, 0, 0, 0, 0,       0, 'h2222, 7, 1, 'h5555, 0, 0, 0, 1);
    tbl[12] = mk(0, 2, 0,      0, 0, 0, 0, 0, 0,       1, 'h3333, 2, 4, 'h5555, 0, 1, 0, 1);
    tbl[13] = mk(0, 2, 0,      0, 0, 0, 0, 1, 'h7777,  0, 'h3333, 2, 4, 'h5555, 0, 1, 0, 1);
    tbl[14] = mk(0, 2, 0,      0, 0, 0, 0, 0, 0,       0, 'h3333, 2, 4, 'h7777, 1, 0, 0, 1);
    tbl[15] = mk(0, 2, 0,      0, 0, 0, 0, 0, 0,       0, 'h3333, 2, 4, 'h7777, 0, 0, 0, 1);
    tbl[16] = mk(0, 2, 0,      0, 0, 0, 0, 0, 0,       0, 'h3333, 2, 4, 'h7777, 0, 0, 0, 1);

    rst = 1'b0;
    idle_inputs();
    #12;
    chk_all_zero("in_reset");
    do_reset();

    // Table: bypass, coef at launch / during WAIT, done during START, overrun, enable drop.
    for (int i = 0; i < 17; i++) begin
      enable = tbl[i].en; rate_div = tbl[i].rd; adc_data = tbl[i].ad; adc_valid = tbl[i].av;
      a1_wr = tbl[i].a1; a2_wr = tbl[i].a2; coef_load = tbl[i].cl;
      flt_done = tbl[i].fd; flt_out = tbl[i].fo;
      #3;
      chk($sformatf("r%0d flt_once", i), 32'(flt_once), 32'(tbl[i].once));
      chk($sformatf("r%0d flt_in", i), 32'(flt_in), 32'(tbl[i].fin));
      chk($sformatf("r%0d flt_a1", i), 32'(flt_a1), 32'(tbl[i].a1o));
      chk($sformatf("r%0d flt_a2", i), 32'(flt_a2), 32'(tbl[i].a2o));
      chk($sformatf("r%0d y", i), 32'(y), 32'(tbl[i].yo));
      chk($sformatf("r%0d y_valid", i), 32'(y_valid), 32'(tbl[i].yv));
      chk($sformatf("r%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("r%0d overrun", i), 32'(overrun), 32'(tbl[i].ovr));
      chk($sformatf("r%0d ovr_count", i), 32'(ovr_count), 32'(tbl[i].oc));
      next_cycle();
    end

    // Periodic launches every 10 cycles.
    do_reset();
    run_rd9(45, "rd9");

    // Reset asserted in WAIT, then a full period before the first relaunch.
    do_reset();
    run_rd9(23, "pre_rst");
    flt_done = 1'b0;
    rst = 1'b0;
    #1;
    chk_all_zero("mid_wait_rst");
    do_reset();
    run_rd9(25, "post_rst");

    // rate_div=1, done 5 cycles after once: overrun at 3,5,7 mod 8, count saturates.
    do_reset();
    model_oc = 0;
    for (int c = 0; c < 700; c++) begin
      enable = 1'b1; rate_div = 16'd1;
      flt_done = (c >= 7) && (c % 8 == 7);
      flt_out = 16'(c);
      #3;
      exp_ovr = (c >= 3) && ((c % 8 == 3) || (c % 8 == 5) || (c % 8 == 7));
      chk($sformatf("sat c%0d overrun", c), 32'(overrun), 32'(exp_ovr));
      chk($sformatf("sat c%0d ovr_count", c), 32'(ovr_count), 32'(model_oc));
      if ((c >= 8) && (c % 8 == 0)) chk($sformatf("sat c%0d y", c), 32'(y), 32'(c - 1));
      if (exp_ovr && model_oc < 255) model_oc++;
      next_cycle();
    end
    chk("sat final ovr_count", 32'(ovr_count), 32'd255);

`ifdef FILTER_CTRL_TIMEOUT_EN
    // No done: abort after 15 WAIT cycles, late done ignored, next tick relaunches.
    do_reset();
    for (int c = 0; c < 46; c++) begin
      enable = 1'b1; rate_div = 16'd19;
      flt_done = (c == 37);
      flt_out = 16'hBEEF;
      #3;
      chk($sformatf("to c%0d flt_once", c), 32'(flt_once), 32'((c == 20) || (c == 40)));
      chk($sformatf("to c%0d timeout", c), 32'(timeout), 32'(c >= 36));
      chk($sformatf("to c%0d y_valid", c), 32'(y_valid), 0);
      next_cycle();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
